snake_dir_scheduler: RTL
========================

// Module: snake_dir_scheduler
// PURPOSE
//  Direction-command scheduler that sits between the raw BtnU/BtnD/BtnL/BtnR pins and snake_core.
//  Debounces the buttons and arbitrates presses that land in the same cycle.
//  Queues accepted turns in a small FIFO and releases exactly one turn per game step.
//  Result: quick double-taps (e.g. Up then Left inside one step) are kept, not lost or merged.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive equal synchronized samples required before a level change is accepted
//  DEPTH            4   FIFO entries; power of two, minimum 2
//  CW               $clog2(DEPTH)+1  width of Count; derived, do not override
// PORTS
//  Clk       in   1   board clock; every register is clocked on posedge
//  Reset     in   1   synchronous, active-high
//  BtnU      in   1   raw asynchronous button
//  BtnD      in   1   raw asynchronous button
//  BtnL      in   1   raw asynchronous button
//  BtnR      in   1   raw asynchronous button
//  Tick      in   1   one-Clk strobe, one per game step
//  Running   in   1   high while the game is in its play state
//  Dir       out  2   current direction: 00 Up, 01 Down, 10 Left, 11 Right
//  DirValid  out  1   one-cycle pulse when Dir is updated
//  Count     out  CW  FIFO occupancy, 0..DEPTH
//  Overflow  out  1   sticky; a press was dropped because the FIFO was full
// BEHAVIOUR
//  Reset values (next edge with Reset=1):
//   - Dir=11, DirValid=0, Count=0, Overflow=0.
//   - Debounced levels=0, debounce counters=0, FIFO pointers=0.
//  Input sync: each button passes a 2-FF synchronizer.
//  Debounce, per button:
//   - Counter clears whenever the synced sample equals the debounced level.
//   - Otherwise the counter increments.
//   - At DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
//  Press event: 0->1 edge of the debounced level. Worst-case latency from pin to event is DEBOUNCE_CYCLES+3 Clk.
//  Arbitration: when several events fire in the same cycle, priority is U > D > L > R; the losers are discarded.
//  Reference direction: the tail (last enqueued) entry, or Dir when the FIFO is empty.
//  Push rule: push the winning event only if all of the following hold:
//   - Running=1;
//   - the event differs from the reference direction (duplicate filter);
//   - it passes the reversal filter, when that filter is compiled in (see CONFIGURATION).
//  Full FIFO: if the push rule is met but Count==DEPTH, drop the event and set Overflow.
//  Pop: on Tick=1 with Running=1 and Count>0 (Count sampled before this cycle's push):
//   - Dir takes the head entry at the next edge;
//   - DirValid=1 for that one cycle.
//  Tick with an empty FIFO: Dir holds, DirValid=0.
//  Push and pop in the same cycle: both happen and Count is unchanged.
//  A push into an empty FIFO coinciding with Tick is not bypassed; it is issued on the following Tick.
//  Pointers wrap modulo DEPTH; Count saturates exactly at DEPTH and 0, with no under- or overrun.
//  Running=0: FIFO flushes (Count=0) at the next edge; Tick and presses are ignored.
//   Dir, Overflow and the debounce state are held.
//  Reset mid-operation: the reset values win over any simultaneous Tick or push.
//  A button held through reset produces no event until it is released and pressed again.
// CONFIGURATION
//  SNAKE_DIR_REVERSAL_BLOCK_EN defined:
//   - Drop any event that is the exact opposite of the reference direction (U<->D, L<->R).
//   - A dropped reversal never sets Overflow.
//  Not defined: reversals are queued like any other turn.
//   snake_core then applies its own collision rule.
// TESTING
//  T1: Reset, then Running=1, press U for 20 cycles, then Tick -> Count 1 then 0; Dir=00; one DirValid pulse.
//  T2: U and L asserted on the same cycle -> only U queued (Count=1); after Tick, Dir=00.
//  T3: press U, L, D, R, U with no Tick -> Count=4, Overflow=1.
//      Then four Ticks -> Dir sequence 00,10,01,11.
//  T4: Dir=11, press L -> queued with the macro undefined.
//      With SNAKE_DIR_REVERSAL_BLOCK_EN defined -> dropped, Count=0, Overflow=0.
//  T5: 10-cycle glitch on BtnD (shorter than DEBOUNCE_CYCLES) -> no event, Count=0.
//  T6: Count=2, drop Running for 1 cycle -> Count=0, Dir unchanged.
//      Reset asserted with Tick active -> Dir=11, DirValid=0.

Source files
------------

// File: rtl/snake_dir_scheduler.sv
// Direction-command scheduler: debounces BtnU/D/L/R, arbitrates, queues turns, releases one per Tick.
// Optional macro SNAKE_DIR_REVERSAL_BLOCK_EN drops turns that reverse the reference direction.
module snake_dir_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 4,
  parameter int CW              = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          BtnU,
  input  logic          BtnD,
  input  logic          BtnL,
  input  logic          BtnR,
  input  logic          Tick,
  input  logic          Running,
  output logic [1:0]    Dir,
  output logic          DirValid,
  output logic [CW-1:0] Count,
  output logic          Overflow
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);

  // Priority U > D > L > R; bit 3 is U, bit 0 is R.
  function automatic logic [1:0] arb_dir(input logic [3:0] ev);
    if (ev[3])      return 2'b00;
    else if (ev[2]) return 2'b01;
    else if (ev[1]) return 2'b10;
    else            return 2'b11;
  endfunction

  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a == (b ^ 2'b01));
  endfunction

  logic [3:0] raw;
  logic [3:0] sync_p0;
  logic [3:0] sync_p1;
  logic [3:0] ev_p2;

  assign raw = {BtnU, BtnD, BtnL, BtnR};

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge Clk) begin
    sync_p0 <= raw;
    sync_p1 <= sync_p0;
  end

  // Stage p2: per-button debounce and rising-edge detect
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic          lvl;
    logic          lvl_d;
    logic          blocked;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        cnt     <= '0;
        lvl     <= 1'b0;
        lvl_d   <= 1'b0;
        blocked <= 1'b1;
      end else if (Running) begin
        lvl_d <= lvl;
        if (sync_p1[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
        // A press is only honoured once the button has been seen released after reset.
        if (!sync_p1[i] && !lvl) blocked <= 1'b0;
      end
    end

    assign ev_p2[i] = lvl & ~lvl_d & ~blocked;
  end

  logic [1:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    win_dir;
  logic [1:0]    tail_dir;
  logic [1:0]    ref_dir;
  logic          push_req;
  logic          push;
  logic          drop;
  logic          pop;

  assign win_dir  = arb_dir(ev_p2);
  assign tail_dir = fifo_mem[wr_ptr - PW'(1)];
  assign ref_dir  = (Count == '0) ? Dir : tail_dir;

`ifdef SNAKE_DIR_REVERSAL_BLOCK_EN
  assign push_req = Running && (|ev_p2) && (win_dir != ref_dir) && !is_opposite(win_dir, ref_dir);
`else
  assign push_req = Running && (|ev_p2) && (win_dir != ref_dir);
`endif

  assign push = push_req && (Count != FULL);
  assign drop = push_req && (Count == FULL);
  assign pop  = Tick && Running && (Count != '0);

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= win_dir;
  end

  // Stage p3: queue control and direction release
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Dir      <= 2'b11;
      DirValid <= 1'b0;
      Count    <= '0;
      Overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      DirValid <= pop;
      if (!Running) begin
        Count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          Dir    <= fifo_mem[rd_ptr];
        end
        if (push && !pop)      Count <= Count + CW'(1);
        else if (pop && !push) Count <= Count - CW'(1);
        if (drop) Overflow <= 1'b1;
      end
    end
  end

endmodule
